// File: rtl/arb_pkg.sv
// Shared types and helpers for the multi-port round-robin arbiter.
// Word comparison ignores the byte-offset bits below word_lsb.
package arb_pkg;

  localparam int unsigned DEFAULT_PAYLOAD_WIDTH = 37;
  localparam int unsigned MAX_ADDR_W            = 64;

  function automatic int unsigned selw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic word_eq(
    input logic [MAX_ADDR_W-1:0] a,
    input logic [MAX_ADDR_W-1:0] b,
    input int unsigned           addr_width,
    input int unsigned           word_lsb
  );
    logic eq;
    eq = 1'b1;
    for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
      if (i >= word_lsb && i < addr_width && a[i] != b[i]) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/rr_masked_pick.sv
// One round-robin pick: first set bit of req scanning upward from ptr,
// wrapping explicitly so that non-power-of-two N works.
module rr_masked_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0] ptr,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx,
  output logic            valid
);

  always_comb begin
    int c;
    // NOTE: every output gets a default before the loop, so no path leaves a latch.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int off = 0; off < N; off++) begin
      c = int'(ptr) + off;
      if (c >= N) c = c - N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/multi_port_rr_arbiter.sv
// Grants up to NPORTS core requests per cycle into registered port slots,
// holding back any core whose word is still parked in a blocked slot.
module multi_port_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NCORES        = 4,
  parameter int unsigned NPORTS        = 2,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned PAYLOAD_WIDTH = DEFAULT_PAYLOAD_WIDTH,
  parameter int unsigned WORD_LSB      = 2,
  localparam int unsigned SELW         = selw(NCORES)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NCORES-1:0]                 req_valid_i,
  output logic [NCORES-1:0]                 req_ready_o,
  input  logic [NCORES*ADDR_WIDTH-1:0]      req_addr_packed_i,
  input  logic [NCORES*PAYLOAD_WIDTH-1:0]   req_payload_packed_i,
  output logic [NPORTS-1:0]                 port_valid_o,
  input  logic [NPORTS-1:0]                 port_ready_i,
  output logic [NPORTS*SELW-1:0]            port_sel_o,
  output logic [NPORTS*ADDR_WIDTH-1:0]      port_addr_o,
  output logic [NPORTS*PAYLOAD_WIDTH-1:0]   port_payload_o
);

  logic [ADDR_WIDTH-1:0]    req_addr    [NCORES];
  logic [PAYLOAD_WIDTH-1:0] req_payload [NCORES];

  logic [NPORTS-1:0]        slot_valid;
  logic [SELW-1:0]          slot_sel     [NPORTS];
  logic [ADDR_WIDTH-1:0]    slot_addr    [NPORTS];
  logic [PAYLOAD_WIDTH-1:0] slot_payload [NPORTS];
  logic [NPORTS-1:0]        slot_free, slot_block, slot_load;
  logic [SELW-1:0]          load_idx [NPORTS];

  logic [SELW-1:0]          rr_ptr, rr_ptr_next;
  logic [NCORES-1:0]        eligible, grant;

  logic [NCORES-1:0]        pick_gnt [NPORTS];
  logic [SELW-1:0]          pick_idx [NPORTS];
  logic [NPORTS-1:0]        pick_vld;

  for (genvar i = 0; i < NCORES; i++) begin : g_unpack
    assign req_addr[i]    = req_addr_packed_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_payload[i] = req_payload_packed_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end

  assign slot_free  = ~slot_valid | port_ready_i;
  assign slot_block =  slot_valid & ~port_ready_i;

  // A core is held back while its word sits in a slot that cannot drain.
  always_comb begin
    eligible = req_valid_i;
    for (int i = 0; i < NCORES; i++) begin
      for (int s = 0; s < NPORTS; s++) begin
        if (slot_block[s] && word_eq(MAX_ADDR_W'(req_addr[i]), MAX_ADDR_W'(slot_addr[s]),
                                     ADDR_WIDTH, WORD_LSB))
          eligible[i] = 1'b0;
      end
    end
  end

  // Each stage sees the previous mask minus its pick and every core sharing that word.
  for (genvar k = 0; k < NPORTS; k++) begin : g_pick
    logic [NCORES-1:0] mask, gnt;
    logic [SELW-1:0]   idx;
    logic              vld;

    if (k == 0) begin : g_head
      assign mask = eligible;
    end else begin : g_tail
      logic [NCORES-1:0] conf;
      always_comb begin
        conf = '0;
        for (int i = 0; i < NCORES; i++)
          conf[i] = g_pick[k-1].vld &&
                    word_eq(MAX_ADDR_W'(req_addr[i]), MAX_ADDR_W'(req_addr[g_pick[k-1].idx]),
                            ADDR_WIDTH, WORD_LSB);
      end
      assign mask = g_pick[k-1].mask & ~g_pick[k-1].gnt & ~conf;
    end

    rr_masked_pick #(.N(NCORES), .SELW(SELW)) u_pick (
      .ptr  (rr_ptr),
      .req  (mask),
      .gnt  (gnt),
      .idx  (idx),
      .valid(vld)
    );

    assign pick_gnt[k] = gnt;
    assign pick_idx[k] = idx;
    assign pick_vld[k] = vld;
  end

  // Pick n lands in the n-th free slot, counted from slot 0.
  always_comb begin
    int              cnt;
    logic [SELW-1:0] last;
    logic            found;
    cnt       = 0;
    last      = '0;
    found     = 1'b0;
    slot_load = '0;
    grant     = '0;
    for (int s = 0; s < NPORTS; s++) load_idx[s] = '0;
    for (int s = 0; s < NPORTS; s++) begin
      if (slot_free[s]) begin
        if (pick_vld[cnt]) begin
          slot_load[s] = 1'b1;
          load_idx[s]  = pick_idx[cnt];
          grant        = grant | pick_gnt[cnt];
          last         = pick_idx[cnt];
          found        = 1'b1;
        end
        cnt++;
      end
    end
    rr_ptr_next = rr_ptr;
    if (found) rr_ptr_next = (last == SELW'(NCORES - 1)) ? '0 : last + 1'b1;
  end

  assign req_ready_o = grant & {NCORES{rst_ni}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      slot_valid <= '0;
      // NOTE: slot storage is a handful of flops, so it is cleared outright rather than left stale.
      for (int s = 0; s < NPORTS; s++) begin
        slot_sel[s]     <= '0;
        slot_addr[s]    <= '0;
        slot_payload[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every slot update based on pre-edge values.
      rr_ptr <= rr_ptr_next;
      for (int s = 0; s < NPORTS; s++) begin
        if (slot_free[s]) begin
          slot_valid[s] <= slot_load[s];
          if (slot_load[s]) begin
            slot_sel[s]     <= load_idx[s];
            slot_addr[s]    <= req_addr[load_idx[s]];
            slot_payload[s] <= req_payload[load_idx[s]];
          end
        end
      end
    end
  end

  assign port_valid_o = slot_valid;
  for (genvar k = 0; k < NPORTS; k++) begin : g_pack
    assign port_sel_o[k*SELW +: SELW]                   = slot_sel[k];
    assign port_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH]       = slot_addr[k];
    assign port_payload_o[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = slot_payload[k];
  end

endmodule

// File: tb/tb_multi_port_rr_arbiter.sv
// Scoreboard bench: stimulus pushes expected slot loads, a negedge monitor
// pops them as each slot is consumed. Runs a 4-core and a 3-core instance.
module tb_multi_port_rr_arbiter;

  localparam int AW = 16;
  localparam int PW = 37;

  typedef struct {
    int          dut;
    int          slot;
    int          core;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]      valid4, ready4;
  logic [AW-1:0]   addr4 [4];
  logic [4*AW-1:0] addr_pk4;
  logic [4*PW-1:0] pay_pk4;
  logic [1:0]      pvalid4, pready4;
  logic [3:0]      psel4;
  logic [2*AW-1:0] paddr4;
  logic [2*PW-1:0] ppay4;

  logic [2:0]      valid3, ready3;
  logic [AW-1:0]   addr3 [3];
  logic [3*AW-1:0] addr_pk3;
  logic [3*PW-1:0] pay_pk3;
  logic [1:0]      pvalid3, pready3;
  logic [3:0]      psel3;
  logic [2*AW-1:0] paddr3;
  logic [2*PW-1:0] ppay3;

  function automatic logic [PW-1:0] pay(input int core, input logic [AW-1:0] a);
    return {5'(core), 16'hbeef, a};
  endfunction

  always_comb begin
    addr_pk4 = '0;
    pay_pk4  = '0;
    for (int i = 0; i < 4; i++) begin
      addr_pk4[i*AW +: AW] = addr4[i];
      pay_pk4[i*PW +: PW]  = pay(i, addr4[i]);
    end
    addr_pk3 = '0;
    pay_pk3  = '0;
    for (int i = 0; i < 3; i++) begin
      addr_pk3[i*AW +: AW] = addr3[i];
      pay_pk3[i*PW +: PW]  = pay(i, addr3[i]);
    end
  end

  multi_port_rr_arbiter #(
    .NCORES(4), .NPORTS(2), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW), .WORD_LSB(2)
  ) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid4), .req_ready_o(ready4),
    .req_addr_packed_i(addr_pk4), .req_payload_packed_i(pay_pk4),
    .port_valid_o(pvalid4), .port_ready_i(pready4),
    .port_sel_o(psel4), .port_addr_o(paddr4), .port_payload_o(ppay4)
  );

  multi_port_rr_arbiter #(
    .NCORES(3), .NPORTS(2), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW), .WORD_LSB(2)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid3), .req_ready_o(ready3),
    .req_addr_packed_i(addr_pk3), .req_payload_packed_i(pay_pk3),
    .port_valid_o(pvalid3), .port_ready_i(pready3),
    .port_sel_o(psel3), .port_addr_o(paddr3), .port_payload_o(ppay3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int s, input int core, input logic [AW-1:0] a);
    exp_t e;
    e.dut  = d;
    e.slot = s;
    e.core = core;
    e.addr = a;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int d, input int s, input logic [1:0] sel,
                        input logic [AW-1:0] a, input logic [PW-1:0] p);
    int hit;
    hit = -1;
    for (int i = 0; i < sb_q.size(); i++)
      if (hit < 0 && sb_q[i].dut == d && sb_q[i].slot == s) hit = i;
    if (hit < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_unexpected d%0d s%0d: got sel %0d addr %0h, required no transfer", d, s, sel, a);
    end else begin
      check($sformatf("sb_d%0d_s%0d", d, s), {8'(sel), a, p},
            {8'(sb_q[hit].core), sb_q[hit].addr, pay(sb_q[hit].core, sb_q[hit].addr)});
      sb_q.delete(hit);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (pvalid4[s] && pready4[s])
          sb_pop(0, s, psel4[s*2 +: 2], paddr4[s*AW +: AW], ppay4[s*PW +: PW]);
        if (pvalid3[s] && pready3[s])
          sb_pop(1, s, psel3[s*2 +: 2], paddr3[s*AW +: AW], ppay3[s*PW +: PW]);
      end
    end
  end

  task automatic set4(input logic [3:0] v, input logic [AW-1:0] a0, a1, a2, a3,
                      input logic [1:0] pr);
    valid4   = v;
    addr4[0] = a0;
    addr4[1] = a1;
    addr4[2] = a2;
    addr4[3] = a3;
    pready4  = pr;
  endtask

  task automatic set3(input logic [2:0] v, input logic [AW-1:0] a0, a1, a2);
    valid3   = v;
    addr3[0] = a0;
    addr3[1] = a1;
    addr3[2] = a2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    pready3 = 2'b11;
    set3(3'b000, 16'h0, 16'h0, 16'h0);
    set4(4'b1111, 16'h00, 16'h10, 16'h20, 16'h30, 2'b11);

    // reset holds everything idle even with all cores requesting
    repeat (2) @(posedge clk);
    settle();
    check("rst_valid", pvalid4, 2'b00);
    check("rst_ready", ready4, 4'b0000);
    check("rst_sel", psel4, 4'h0);
    check("rst_addr", paddr4, 32'h0);
    check("rst_payload_zero", (ppay4 == '0), 1'b1);
    step();
    rst_n = 1'b1;

    // all four requesting, ports ready: 0/1 then 2/3
    push(0, 0, 0, 16'h00);
    push(0, 1, 1, 16'h10);
    settle();
    check("rr_c1_ready", ready4, 4'b0011);
    step();
    push(0, 0, 2, 16'h20);
    push(0, 1, 3, 16'h30);
    settle();
    check("rr_c2_ready", ready4, 4'b1100);
    check("rr_c2_valid", pvalid4, 2'b11);
    step();
    set4(4'b0000, 16'h00, 16'h10, 16'h20, 16'h30, 2'b11);
    settle();
    check("idle_ready", ready4, 4'b0000);
    step();
    settle();
    check("drain_valid", pvalid4, 2'b00);

    // same-cycle word conflict between cores 0 and 1
    step();
    set4(4'b0111, 16'h104, 16'h106, 16'h200, 16'h0, 2'b11);
    push(0, 0, 0, 16'h104);
    push(0, 1, 2, 16'h200);
    settle();
    check("conf_ready", ready4, 4'b0101);
    step();
    set4(4'b0010, 16'h104, 16'h106, 16'h200, 16'h0, 2'b11);
    push(0, 0, 1, 16'h106);
    settle();
    check("conf_retry_ready", ready4, 4'b0010);
    step();
    set4(4'b0000, 16'h104, 16'h106, 16'h200, 16'h0, 2'b11);
    settle();
    check("conf_slot_valid", pvalid4, 2'b01);
    step();

    // backpressure: fill both slots, then stall
    set4(4'b1111, 16'h40, 16'h50, 16'h60, 16'h70, 2'b11);
    push(0, 0, 2, 16'h60);
    push(0, 1, 3, 16'h70);
    settle();
    check("bp_fill_ready", ready4, 4'b1100);
    step();
    set4(4'b0011, 16'h40, 16'h61, 16'h60, 16'h70, 2'b00);
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("bp_hold%0d_ready", c), ready4, 4'b0000);
      check($sformatf("bp_hold%0d_valid", c), pvalid4, 2'b11);
      check($sformatf("bp_hold%0d_sel", c), psel4, 4'b1110);
      check($sformatf("bp_hold%0d_addr", c), paddr4, {16'h0070, 16'h0060});
      step();
    end
    set4(4'b0011, 16'h40, 16'h61, 16'h60, 16'h70, 2'b10);
    push(0, 1, 0, 16'h40);
    settle();
    check("bp_one_ready", ready4, 4'b0001);
    step();
    check("bp_one_sel", psel4, 4'b0010);
    set4(4'b0010, 16'h40, 16'h61, 16'h60, 16'h70, 2'b10);
    settle();
    check("bp_word_block_ready", ready4, 4'b0000);
    check("bp_slot0_held_addr", paddr4[AW-1:0], 16'h0060);
    step();
    set4(4'b0010, 16'h40, 16'h61, 16'h60, 16'h70, 2'b11);
    push(0, 0, 1, 16'h61);
    settle();
    check("bp_unblock_ready", ready4, 4'b0010);
    step();

    // single requestor is granted every cycle
    set4(4'b1000, 16'h0, 16'h0, 16'h0, 16'h80, 2'b11);
    for (int c = 0; c < 3; c++) begin
      push(0, 0, 3, 16'h80);
      settle();
      check($sformatf("single%0d_ready", c), ready4, 4'b1000);
      step();
    end
    set4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h80, 2'b11);
    settle();
    step();
    settle();
    check("single_drain_valid", pvalid4, 2'b00);
    step();

    // async reset between edges drops loaded slots and the pointer
    set4(4'b1111, 16'h00, 16'h10, 16'h20, 16'h30, 2'b11);
    push(0, 0, 0, 16'h00);
    push(0, 1, 1, 16'h10);
    settle();
    check("ar_load_ready", ready4, 4'b0011);
    step();
    set4(4'b0000, 16'h00, 16'h10, 16'h20, 16'h30, 2'b00);
    settle();
    rst_n = 1'b0;
    #1;
    check("ar_valid", pvalid4, 2'b00);
    check("ar_ready", ready4, 4'b0000);
    for (int i = sb_q.size() - 1; i >= 0; i--)
      if (sb_q[i].dut == 0) sb_q.delete(i);
    step();
    rst_n = 1'b1;
    set4(4'b1111, 16'h00, 16'h10, 16'h20, 16'h30, 2'b11);
    push(0, 0, 0, 16'h00);
    push(0, 1, 1, 16'h10);
    settle();
    check("ar_ptr0_ready", ready4, 4'b0011);
    step();
    set4(4'b0000, 16'h00, 16'h10, 16'h20, 16'h30, 2'b11);
    settle();
    step();
    settle();
    check("ar_drain_valid", pvalid4, 2'b00);
    step();

    // three cores: pointer wraps 2 -> 0 without a power-of-two modulus
    set3(3'b111, 16'h00, 16'h10, 16'h20);
    push(1, 0, 0, 16'h00);
    push(1, 1, 1, 16'h10);
    settle();
    check("nc3_first_ready", ready3, 3'b011);
    step();
    set3(3'b101, 16'h00, 16'h10, 16'h20);
    push(1, 0, 2, 16'h20);
    push(1, 1, 0, 16'h00);
    settle();
    check("nc3_wrap_ready", ready3, 3'b101);
    step();
    set3(3'b010, 16'h00, 16'h10, 16'h20);
    push(1, 0, 1, 16'h10);
    settle();
    check("nc3_ptr1_ready", ready3, 3'b010);
    step();
    set3(3'b100, 16'h00, 16'h10, 16'h20);
    push(1, 0, 2, 16'h20);
    settle();
    check("nc3_ptr2_ready", ready3, 3'b100);
    step();
    set3(3'b111, 16'h00, 16'h10, 16'h20);
    push(1, 0, 0, 16'h00);
    push(1, 1, 1, 16'h10);
    settle();
    check("nc3_ptr0_ready", ready3, 3'b011);
    step();
    set3(3'b000, 16'h00, 16'h10, 16'h20);
    settle();
    step();
    settle();
    check("nc3_drain_valid", pvalid3, 2'b00);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_port_rr_arbiter.md
Name: multi_port_rr_arbiter

Overview:
- Round-robin arbiter with state. It grants up to NPORTS of NCORES core requests per cycle onto NPORTS memory ports.
- It generalises the single- and dual-issue combinational arbiters. The number of grants is parametrised, and the block owns its rotating pointer.
- Each port has a registered output slot with a valid/ready handshake, so port backpressure is absorbed here.
- A word-address conflict filter prevents two in-flight accesses to the same word. It sits between the cores' data-side request buses and the banked DMEM.

Parameters:
- NCORES, `NCORES, number of requestors (any value ≥2, not necessarily a power of two).
- NPORTS, 2, number of memory ports / grants per cycle (1..NCORES).
- ADDR_WIDTH, `DMEM_ADDRW, request address width.
- PAYLOAD_WIDTH, 37, opaque per-request payload (wdata + byte enables + we).
- WORD_LSB, 2, address bits below this are ignored for conflict checks.

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset. One clock; reset is asynchronous and active-low.
- req_valid_i, input, NCORES: per-core request valid.
- req_ready_o, output, NCORES: per-core accept; transfer when valid&ready.
- req_addr_packed_i, input, NCORES*ADDR_WIDTH: core i address at slice i.
- req_payload_packed_i, input, NCORES*PAYLOAD_WIDTH: core i payload at slice i.
- port_valid_o, output, NPORTS: slot k holds a request.
- port_ready_i, input, NPORTS: port k consumes slot k this cycle.
- port_sel_o, output, NPORTS*SELW: granted core index per slot, where SELW=$clog2(NCORES).
- port_addr_o, output, NPORTS*ADDR_WIDTH: registered address per slot.
- port_payload_o, output, NPORTS*PAYLOAD_WIDTH: registered payload per slot.

Behaviour:
- Reset (async, rst_ni=0):
  - rr_ptr=0.
  - port_valid_o=0; port_sel_o, port_addr_o and port_payload_o all 0.
  - req_ready_o=0 while in reset; it is combinational, so it follows port_valid_o=0 once reset is released.
  - Reset mid-transfer drops held slots silently.
- Slot k is free when !port_valid_o[k] || port_ready_i[k]. A draining slot may reload in the same cycle.
- Slot k is blocking when port_valid_o[k] && !port_ready_i[k].
- Eligible core i: req_valid_i[i], and addr_i[ADDR_WIDTH-1:WORD_LSB] differs from the address of every blocking slot.
- Selection (combinational, same cycle):
  - Scan eligible cores starting at rr_ptr, wrapping modulo NCORES.
  - The first pick fills the lowest-index free slot, the second pick the next free slot, and so on, up to the number of free slots.
  - A later pick is skipped if its word address equals the word address of an earlier pick in the same cycle.
- req_ready_o[i]=1 exactly for picked cores. It depends combinationally on req_valid_i, the addresses and port_ready_i.
  - Requestors must hold valid/addr/payload stable until ready.
- Clock edge:
  - Picked slots load sel/addr/payload and set valid.
  - Free slots not reloaded clear valid.
  - Blocking slots hold all fields unchanged.
- rr_ptr update:
  - If ≥1 grant: rr_ptr <= (index of last pick in scan order + 1) mod NCORES. A non-power-of-2 NCORES wraps explicitly (NCORES-1 -> 0).
  - No grant: rr_ptr unchanged.
- Latency: one cycle from request acceptance to port_valid_o. Throughput is NPORTS/cycle with ports always ready.
- Boundary cases:
  - All slots blocking: req_ready_o=0.
  - No requests: outputs drain; pointer holds.
  - A single requestor is granted every cycle it is eligible.
- Ordering: a conflicting core waits while the same word is held in a blocking slot, which preserves per-word order.
- Fairness: each requesting core is granted within ceil(NCORES/NPORTS) rounds of grants, absent conflicts.

Decomposition:
- Package arb_pkg holds:
  - a selw(n) helper returning max(1,$clog2(n));
  - a word-compare function over ADDR_WIDTH/WORD_LSB;
  - the default PAYLOAD_WIDTH localparam.
- Sub-module rr_masked_pick (inputs: ptr, request mask; outputs: one-hot grant, binary index, valid). It is chained NPORTS times, each stage masked by earlier picks and by their word-conflicting cores.
- The top module holds the slots, rr_ptr, and the pack/unpack logic.

Test Plan:
1. Reset: hold rst_ni=0, drive all req_valid_i=1 → port_valid_o=00, req_ready_o=0000. After release, rr_ptr=0 and the first grants go to cores 0 and 1.
2. NCORES=4, NPORTS=2, ports ready, addrs 0x00/0x10/0x20/0x30, all valid:
   - cycle 1: ready=0011, slot0.sel=0, slot1.sel=1, ptr=2;
   - cycle 2: ready=1100, sels 2/3, ptr=0.
3. Same-cycle conflict: core0 addr 0x104, core1 addr 0x106, core2 addr 0x200, ptr=0 → grants to 0 and 2, core1 waits. Next cycle, with slot0 drained, core1 is granted.
4. Backpressure:
   - both slots full, port_ready_i=00 → req_ready_o=0000, outputs stable 3 cycles;
   - then port_ready_i=10 → exactly one grant, loaded into slot1 only;
   - a core matching slot0's held word stays blocked.
5. Non-power-of-2 wrap: NCORES=3, ptr=2, cores 0 and 2 request → slot0=core2, slot1=core0, ptr=1. Later, with ptr=2 and only core2 requesting → ptr=0.
6. Async reset mid-operation: drop rst_ni between edges with slots valid → port_valid_o=00 immediately, before the next edge. After release, rr_ptr=0.
